gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
- Run/stop sequencer wrapped around a function-based gray-code counter.
- Accepts start, stop and hold commands plus a direction and a programmable terminal count.
- Steps an internal binary count and presents it as gray code.
- Flags wrap-around and one-shot completion to the surrounding control logic.

Parameters:
- WIDTH, 4, count and gray output width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- res  input  1  synchronous active-high reset, sampled on rising edge of clk.
- start  input  1  begin a count sequence; honoured only in IDLE.
- stop  input  1  abort a sequence; highest-priority command.
- hold  input  1  freeze the count while in RUN.
- dir  input  1  direction, 1 = up, 0 = down; latched at start.
- one_shot  input  1  1 = stop at terminal, 0 = free-run with wrap; latched at start.
- limit  input  WIDTH  terminal binary count; latched at start.
- gray  output  WIDTH  gray code of internal count, bin ^ (bin >> 1).
- busy  output  1  high while in RUN.
- wrap  output  1  one-cycle pulse on each free-run wrap.
- done  output  1  one-cycle pulse when a one-shot sequence completes.

Behaviour:
- Reset: res=1 at a clk edge forces the following; res overrides every other input:
  - state=IDLE
  - bin=0, so gray=0
  - latched dir/one_shot/limit = 0
  - busy=0, wrap=0, done=0
- Registers: bin, the latched copies dir_q/one_shot_q/limit_q, and the state are registered. gray is combinational from bin, adding zero latency after bin. busy, wrap and done are registered.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and stop=0: latch dir, one_shot and limit. Load bin=0 when dir=1, or bin=limit when dir=0. Go to RUN; busy=1 from the next cycle.
  - start=1 and stop=1 in the same cycle: stay in IDLE, no load.
  - Otherwise bin holds, so gray keeps its last value.
- RUN, evaluated in priority order each cycle:
  - stop=1: go to IDLE; bin keeps its value; busy=0 next cycle; no done pulse.
  - hold=1: bin is frozen; stay in RUN; no pulses.
  - Up, bin==limit_q, one_shot_q=1: go to DONE; bin holds.
  - Up, bin==limit_q, one_shot_q=0: bin=0; wrap=1 for one cycle.
  - Up, otherwise: bin=bin+1.
  - Down, bin==0, one_shot_q=1: go to DONE.
  - Down, bin==0, one_shot_q=0: bin=limit_q; wrap=1 for one cycle.
  - Down, otherwise: bin=bin-1.
  - start is ignored in RUN.
- DONE:
  - Lasts exactly one cycle, with done=1 and busy=0; then returns to IDLE unconditionally.
  - gray holds the terminal value until the next start.
  - start and stop are ignored in DONE.
- Terminal condition: a one-shot up sequence visits 0..limit (limit+1 values). done asserts in the cycle after bin first equals limit in an un-held RUN cycle.
- Boundaries:
  - limit=0, free-run: wrap pulses every un-held cycle and gray stays 0.
  - limit=0, one-shot: DONE is reached after one RUN cycle.
  - limit = 2^WIDTH-1, up: wraps at the natural overflow boundary.
  - limit changes during RUN have no effect, because the latched copy is used.
- Arithmetic: bin is unsigned WIDTH bits. Increment and decrement never overflow, because terminal detection precedes the step.
- Reset mid-RUN: immediate return to the reset state on that edge; no done or wrap pulse.

Decomposition:
- Shared package gray_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - function bin2gray(bin), reused by the existing counter designs.
  - function gray2bin, for checker use.
- Sub-module gray_step: registered binary count with load, up/down enable and terminal-compare output. The FSM lives in gray_seq_ctrl.

Test Plan:
- Reset check: res=1 for 2 cycles mid-RUN -> gray=0, busy=0, wrap=0, done=0 on the following edge.
- One-shot up: WIDTH=4, limit=5, dir=1, one_shot=1, start pulse -> gray steps 0000, 0001, 0011, 0010, 0110, 0111; done=1 for exactly one cycle after 0111; busy=0 afterwards; gray holds 0111.
- Free-run down: limit=3, dir=0, one_shot=0 -> bin sequence 3, 2, 1, 0, 3, 2...; gray 0010, 0011, 0001, 0000, 0010...; wrap=1 only in the cycle gray returns to 0010.
- Hold and stop priority:
  - hold=1 for 3 cycles at bin=2 -> gray frozen at 0011, no pulses.
  - Then hold=1 with stop=1 together -> IDLE next cycle, busy=0, gray stays 0011, done stays 0.
- Command conflicts:
  - start=1 with stop=1 in IDLE -> stays IDLE, busy=0.
  - start pulse during RUN -> count continues unchanged.
  - limit changed 5->9 mid-RUN -> done still fires at bin=5.
- Edge limits:
  - limit=0, one_shot=1 -> done one cycle after busy rises.
  - limit=15, up, free-run -> wrap after gray 1000 returns to 0000.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the gray-code counter family.
package gray_pkg;

  localparam int unsigned GRAY_MAXW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Binary to gray conversion, sized for the widest supported counter.
  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary conversion, used by checkers.
  function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
    logic [GRAY_MAXW-1:0] b;
    b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
    for (int unsigned i = GRAY_MAXW - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// Command and status bundle for the gray-code sequencer.
interface gray_seq_ctrl_if #(parameter int unsigned WIDTH = 4);
  logic             start;
  logic             stop;
  logic             hold;
  logic             dir;
  logic             one_shot;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] gray;
  logic             busy;
  logic             wrap;
  logic             done;

  modport master (
    output start, stop, hold, dir, one_shot, limit,
    input  gray, busy, wrap, done
  );

  modport slave (
    input  start, stop, hold, dir, one_shot, limit,
    output gray, busy, wrap, done
  );
endinterface

// File: rtl/gray_step.sv
// Binary count register with load, up/down step and terminal compare.
module gray_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] bin,
  output logic             term
);

  // Count register: load has priority over stepping.
  always_ff @(posedge clk) begin
    if (res) begin
      bin <= '0;
    end else if (load) begin
      bin <= load_val;
    end else if (en) begin
      bin <= up ? bin + 1'b1 : bin - 1'b1;
    end
  end

  // Terminal is limit when counting up, zero when counting down.
  always_comb begin
    term = up ? (bin == limit) : (bin == '0);
  end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Run/stop sequencer driving a gray-code counter.
module gray_seq_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic            clk,
  input  logic            res,
  gray_seq_ctrl_if.slave  bus
);

  state_t           state, state_nx;
  logic             dir_q, one_shot_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] bin;
  logic             term;
  logic             load, en, latch, wrap_nx;
  logic [WIDTH-1:0] load_val;
  logic             busy_q, wrap_q, done_q;

  gray_step #(.WIDTH(WIDTH)) u_step (
    .clk      (clk),
    .res      (res),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up       (dir_q),
    .limit    (limit_q),
    .bin      (bin),
    .term     (term)
  );

  // State register and latched sequence settings.
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= ST_IDLE;
      dir_q      <= 1'b0;
      one_shot_q <= 1'b0;
      limit_q    <= '0;
    end else begin
      state <= state_nx;
      if (latch) begin
        dir_q      <= bus.dir;
        one_shot_q <= bus.one_shot;
        limit_q    <= bus.limit;
      end
    end
  end

  // Next-state decode; stop outranks hold, hold outranks terminal detection.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.start && !bus.stop) state_nx = ST_RUN;
      ST_RUN: begin
        if (bus.stop)                            state_nx = ST_IDLE;
        else if (!bus.hold && term && one_shot_q) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath controls: load on start or wrap, step otherwise.
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    en       = 1'b0;
    latch    = 1'b0;
    wrap_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          latch    = 1'b1;
          load     = 1'b1;
          load_val = bus.dir ? '0 : bus.limit;
        end
      end
      ST_RUN: begin
        if (!bus.stop && !bus.hold) begin
          if (term) begin
            if (!one_shot_q) begin
              load     = 1'b1;
              load_val = dir_q ? '0 : limit_q;
              wrap_nx  = 1'b1;
            end
          end else begin
            en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered status flags, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (res) begin
      busy_q <= 1'b0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nx == ST_RUN);
      wrap_q <= wrap_nx;
      done_q <= (state_nx == ST_DONE);
    end
  end

  // Gray output is purely combinational from the count.
  always_comb begin
    bus.gray = WIDTH'(bin2gray(GRAY_MAXW'(bin)));
    bus.busy = busy_q;
    bus.wrap = wrap_q;
    bus.done = done_q;
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl with WIDTH=4.
module tb_gray_seq_ctrl;
  import gray_pkg::*;

  logic clk = 1'b0;
  logic res;
  int   checks = 0;
  int   errors = 0;

  gray_seq_ctrl_if #(.WIDTH(4)) bus ();

  gray_seq_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic busy, input logic wrap, input logic done);
    check({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    check({tag, ".wrap"}, 32'(bus.wrap), 32'(wrap));
    check({tag, ".done"}, 32'(bus.done), 32'(done));
  endtask

  initial begin
    logic [3:0] up_seq [4];
    logic [3:0] dn_gray [5];
    logic       dn_wrap [5];
    up_seq  = '{4'd3, 4'd2, 4'd6, 4'd7};
    dn_gray = '{4'd3, 4'd1, 4'd0, 4'd2, 4'd3};
    dn_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    res = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
    bus.dir = 1'b0; bus.one_shot = 1'b0; bus.limit = 4'd0;
    tick(); tick();
    check("rst.gray", 32'(bus.gray), 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    res = 1'b0;

    // One-shot up to 5, with a limit change and a stray start mid-run.
    bus.start = 1'b1; bus.dir = 1'b1; bus.one_shot = 1'b1; bus.limit = 4'd5;
    tick();
    bus.start = 1'b0;
    check("os.g0", 32'(bus.gray), 32'd0);
    check("os.busy0", 32'(bus.busy), 32'd1);
    bus.limit = 4'd9; bus.start = 1'b1; bus.dir = 1'b0;
    tick();
    bus.start = 1'b0;
    check("os.g1", 32'(bus.gray), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("os.gray", 32'(bus.gray), 32'(up_seq[i]));
      check_flags("os.run", 1'b1, 1'b0, 1'b0);
    end
    tick();
    check("os.term.gray", 32'(bus.gray), 32'd7);
    check_flags("os.term", 1'b0, 1'b0, 1'b1);
    tick();
    check("os.after.gray", 32'(bus.gray), 32'd7);
    check("os.after.bin", 32'(gray2bin(16'(bus.gray))), 32'd5);
    check_flags("os.after", 1'b0, 1'b0, 1'b0);

    // Free-run down from 3.
    bus.start = 1'b1; bus.dir = 1'b0; bus.one_shot = 1'b0; bus.limit = 4'd3;
    tick();
    bus.start = 1'b0;
    check("fr.g0", 32'(bus.gray), 32'd2);
    check_flags("fr.start", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fr.gray", 32'(bus.gray), 32'(dn_gray[i]));
      check("fr.wrap", 32'(bus.wrap), 32'(dn_wrap[i]));
    end

    // Hold three cycles at bin=2, then hold+stop together.
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold.gray", 32'(bus.gray), 32'd3);
      check_flags("hold", 1'b1, 1'b0, 1'b0);
    end
    bus.stop = 1'b1;
    tick();
    check("stop.gray", 32'(bus.gray), 32'd3);
    check_flags("stop", 1'b0, 1'b0, 1'b0);
    bus.hold = 1'b0; bus.stop = 1'b0;
    tick();
    check("idle.gray", 32'(bus.gray), 32'd3);

    // start and stop together in IDLE: no load, no run.
    bus.start = 1'b1; bus.stop = 1'b1; bus.dir = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("ss.gray", 32'(bus.gray), 32'd3);
    check("ss.busy", 32'(bus.busy), 32'd0);
    tick();
    check("ss.busy2", 32'(bus.busy), 32'd0);

    // limit=0 one-shot: DONE after a single RUN cycle.
    bus.start = 1'b1; bus.dir = 1'b1; bus.one_shot = 1'b1; bus.limit = 4'd0;
    tick();
    bus.start = 1'b0;
    check("l0os.gray", 32'(bus.gray), 32'd0);
    check_flags("l0os.run", 1'b1, 1'b0, 1'b0);
    tick();
    check_flags("l0os.done", 1'b0, 1'b0, 1'b1);
    tick();
    check_flags("l0os.idle", 1'b0, 1'b0, 1'b0);

    // limit=0 free-run: wrap every cycle, gray stays 0.
    bus.start = 1'b1; bus.one_shot = 1'b0;
    tick();
    bus.start = 1'b0;
    check_flags("l0fr.run", 1'b1, 1'b0, 1'b0);
    tick();
    check("l0fr.gray1", 32'(bus.gray), 32'd0);
    check("l0fr.wrap1", 32'(bus.wrap), 32'd1);
    tick();
    check("l0fr.gray2", 32'(bus.gray), 32'd0);
    check("l0fr.wrap2", 32'(bus.wrap), 32'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_flags("l0fr.stop", 1'b0, 1'b0, 1'b0);

    // limit=15 up free-run: natural overflow wrap.
    bus.start = 1'b1; bus.limit = 4'd15;
    tick();
    bus.start = 1'b0;
    check("l15.g0", 32'(bus.gray), 32'd0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("l15.gray", 32'(bus.gray), 32'(i ^ (i >> 1)));
      check("l15.wrap", 32'(bus.wrap), 32'd0);
    end
    check("l15.top", 32'(bus.gray), 32'b1000);
    tick();
    check("l15.wgray", 32'(bus.gray), 32'd0);
    check("l15.wrap.hi", 32'(bus.wrap), 32'd1);
    tick();
    check("l15.g1", 32'(bus.gray), 32'd1);
    check("l15.wrap.lo", 32'(bus.wrap), 32'd0);

    // Reset for two cycles mid-RUN.
    res = 1'b1;
    tick();
    check("mrst1.gray", 32'(bus.gray), 32'd0);
    check_flags("mrst1", 1'b0, 1'b0, 1'b0);
    tick();
    check("mrst2.gray", 32'(bus.gray), 32'd0);
    check_flags("mrst2", 1'b0, 1'b0, 1'b0);
    res = 1'b0;
    tick();
    check("mrst.idle.gray", 32'(bus.gray), 32'd0);
    check_flags("mrst.idle", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
